simon_sequencer: RTL

Pattern generator and player for the Simon Says game. On each round request it appends one pseudo-random direction to a stored sequence, then replays the whole sequence to the arrow-drawing FSM as timed direction/click strobes. It drives the drawing FSM's `direction` and `clicked` inputs in playback mode. A round-done pulse tells game control to start accepting player input.

---
 rtl/simon_pkg.sv | 27 ++
 rtl/simon_sequencer_if.sv | 33 +++
 rtl/simon_lfsr.sv | 32 +++
 rtl/simon_sequencer.sv | 161 ++++++++++++++++
 4 files changed

// File: rtl/simon_pkg.sv
// Shared definitions for the Simon Says blocks: direction codes, sequencer
// state encoding and a small helper that turns a stored step into a code.
package simon_pkg;

  localparam logic [2:0] DIR_UP    = 3'd0;
  localparam logic [2:0] DIR_DOWN  = 3'd1;
  localparam logic [2:0] DIR_RIGHT = 3'd2;
  localparam logic [2:0] DIR_LEFT  = 3'd3;
  localparam logic [2:0] DIR_NONE  = 3'd4;

  // Fallback seed for the LFSR; an all-zero seed would lock it up.
  localparam logic [15:0] LFSR_DEFAULT_SEED = 16'hACE1;

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_EXTEND   = 3'd1,
    ST_SHOW_ON  = 3'd2,
    ST_SHOW_OFF = 3'd3,
    ST_DONE     = 3'd4
  } seq_state_t;

  // A stored step is one of the four arrows; NONE is the only code with bit 2 set.
  function automatic logic [2:0] step_dir(input logic [1:0] code);
    return {1'b0, code};
  endfunction

endpackage

// File: rtl/simon_sequencer_if.sv
// Control/status bundle between game control and the pattern sequencer.
//
// Request semantics: there is no valid/ready pair. `start` is a level that the
// sequencer samples only while idle (busy=0); a start seen while busy is
// dropped, never queued. `clear` is honoured in every state and wins over
// `start`. `busy` is the only back-pressure indication; `done` is a one-cycle
// pulse marking the end of a round's playback.
interface simon_sequencer_if
  import simon_pkg::*;
#(
  parameter int LEN_W = 5
);
  logic             start;
  logic             clear;
  logic [2:0]       direction;
  logic             clicked;
  logic             lit;
  logic             busy;
  logic             done;
  logic [LEN_W-1:0] length;
  logic             full;
  seq_state_t       state;

  modport master (
    output start, clear,
    input  direction, clicked, lit, busy, done, length, full, state
  );

  modport slave (
    input  start, clear,
    output direction, clicked, lit, busy, done, length, full, state
  );
endinterface

// File: rtl/simon_lfsr.sv
// 16-bit Fibonacci LFSR (taps 16/14/13/11), free running, right shifting.
// A zero seed is replaced by the default seed so the register never locks.
module simon_lfsr
  import simon_pkg::*;
#(
  parameter logic [15:0] SEED  = 16'hACE1,
  parameter int          OUT_W = 16
) (
  input  logic             clock,
  input  logic             reset,
  output logic [OUT_W-1:0] o_value
);

  localparam logic [15:0] EFF_SEED = (SEED == 16'h0000) ? LFSR_DEFAULT_SEED : SEED;

  logic [15:0] r_lfsr;
  logic        w_feedback;

  assign w_feedback = r_lfsr[0] ^ r_lfsr[2] ^ r_lfsr[3] ^ r_lfsr[5];

  // Advance one step every cycle; reset reloads the seed.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_lfsr <= EFF_SEED;
    end else begin
      r_lfsr <= {w_feedback, r_lfsr[15:1]};
    end
  end

  assign o_value = r_lfsr[OUT_W-1:0];

endmodule

// File: rtl/simon_sequencer.sv
// Simon Says pattern sequencer: each round appends one pseudo-random arrow to
// the stored sequence and replays the whole sequence as timed show/gap steps.
module simon_sequencer
  import simon_pkg::*;
#(
  parameter int          MAX_LEN    = 16,
  parameter int          ON_CYCLES  = 25_000_000,
  parameter int          OFF_CYCLES = 12_500_000,
  parameter logic [15:0] LFSR_SEED  = 16'hACE1
) (
  input  logic              clock,
  input  logic              reset,
  simon_sequencer_if.slave  bus
);

  localparam int LW   = $clog2(MAX_LEN + 1);
  localparam int IW   = (MAX_LEN > 1) ? $clog2(MAX_LEN) : 1;
  localparam int TMAX = (ON_CYCLES > OFF_CYCLES) ? ON_CYCLES : OFF_CYCLES;
  localparam int TW   = $clog2(TMAX + 1);

  localparam logic [TW-1:0] ON_LOAD  = TW'(ON_CYCLES - 1);
  localparam logic [TW-1:0] OFF_LOAD = TW'(OFF_CYCLES - 1);
  localparam logic [LW-1:0] LEN_MAX  = LW'(MAX_LEN);

  seq_state_t    r_state;
  logic [1:0]    r_mem [MAX_LEN];
  logic [LW-1:0] r_length;
  logic [LW-1:0] r_idx;
  logic [TW-1:0] r_timer;
  logic [2:0]    r_direction;
  logic          r_clicked;
  logic          r_lit;
  logic          r_busy;
  logic          r_done;
  logic          r_full;

  logic [1:0]    w_lfsr_code;
  logic [LW-1:0] w_len_inc;
  logic [LW-1:0] w_idx_inc;
  logic [1:0]    w_first_code;
  logic [1:0]    w_next_code;

  simon_lfsr #(
    .SEED  (LFSR_SEED),
    .OUT_W (2)
  ) u_lfsr (
    .clock   (clock),
    .reset   (reset),
    .o_value (w_lfsr_code)
  );

  assign w_len_inc = r_length + 1'b1;
  assign w_idx_inc = r_idx + 1'b1;

  // Step 0 is shown in the cycle right after EXTEND; if the store was empty the
  // value is being written in that same edge, so take it straight from the LFSR.
  assign w_first_code = (!r_full && (r_length == '0)) ? w_lfsr_code : r_mem[0];
  assign w_next_code  = r_mem[w_idx_inc[IW-1:0]];

  // Sequence store: one new step per round, written only in EXTEND when room remains.
  always_ff @(posedge clock) begin
    if (r_state == ST_EXTEND && !bus.clear && !r_full) begin
      r_mem[r_length[IW-1:0]] <= w_lfsr_code;
    end
  end

  // Round FSM with registered outputs; clear aborts from any state.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_state     <= ST_IDLE;
      r_length    <= '0;
      r_idx       <= '0;
      r_timer     <= '0;
      r_direction <= DIR_NONE;
      r_clicked   <= 1'b0;
      r_lit       <= 1'b0;
      r_busy      <= 1'b0;
      r_done      <= 1'b0;
      r_full      <= 1'b0;
    end else if (bus.clear) begin
      r_state     <= ST_IDLE;
      r_length    <= '0;
      r_idx       <= '0;
      r_timer     <= '0;
      r_direction <= DIR_NONE;
      r_clicked   <= 1'b0;
      r_lit       <= 1'b0;
      r_busy      <= 1'b0;
      r_done      <= 1'b0;
      r_full      <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (bus.start) begin
            r_state <= ST_EXTEND;
            r_busy  <= 1'b1;
          end
        end
        ST_EXTEND: begin
          // A full store replays the existing sequence unchanged.
          if (!r_full) begin
            r_length <= w_len_inc;
            r_full   <= (w_len_inc == LEN_MAX);
          end
          r_idx       <= '0;
          r_timer     <= ON_LOAD;
          r_state     <= ST_SHOW_ON;
          r_direction <= step_dir(w_first_code);
          r_lit       <= 1'b1;
          r_clicked   <= 1'b1;
        end
        ST_SHOW_ON: begin
          r_clicked <= 1'b0;
          if (r_timer == '0) begin
            r_state     <= ST_SHOW_OFF;
            r_timer     <= OFF_LOAD;
            r_direction <= DIR_NONE;
            r_lit       <= 1'b0;
          end else begin
            r_timer <= r_timer - 1'b1;
          end
        end
        ST_SHOW_OFF: begin
          if (r_timer == '0) begin
            r_idx <= w_idx_inc;
            if (w_idx_inc == r_length) begin
              r_state <= ST_DONE;
              r_done  <= 1'b1;
            end else begin
              r_state     <= ST_SHOW_ON;
              r_timer     <= ON_LOAD;
              r_direction <= step_dir(w_next_code);
              r_lit       <= 1'b1;
              r_clicked   <= 1'b1;
            end
          end else begin
            r_timer <= r_timer - 1'b1;
          end
        end
        ST_DONE: begin
          r_done  <= 1'b0;
          r_busy  <= 1'b0;
          r_state <= ST_IDLE;
        end
        default: begin
          r_state <= ST_IDLE;
        end
      endcase
    end
  end

  assign bus.direction = r_direction;
  assign bus.clicked   = r_clicked;
  assign bus.lit       = r_lit;
  assign bus.busy      = r_busy;
  assign bus.done      = r_done;
  assign bus.length    = r_length;
  assign bus.full      = r_full;
  assign bus.state     = r_state;

endmodule
